// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and sizing helper for the binary-to-BCD display path
package bcd_pkg;

    // Width of one BCD digit.
    localparam int BCD_NIB_W = 4;

    // Conversion sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_e;

    // Smallest digit count whose decimal range covers every W-bit unsigned value.
    function automatic int min_digits(input int w);
        longint max_val;
        longint pow10;
        int     d;
        max_val = (longint'(1) <<< w) - 1;
        pow10   = 1;
        d       = 0;
        while (pow10 <= max_val) begin
            pow10 = pow10 * 10;
            d     = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction (add 3 when the digit is 5 or more)
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [BCD_NIB_W-1:0] nib_i,
    output logic [BCD_NIB_W-1:0] nib_o
);

    // Values 5..9 become 8..12 so the following left shift carries into the next digit;
    // the largest legal input is 9, so 4 bits never overflow.
    always_comb begin
        nib_o = nib_i;
        if (nib_i >= 4'd5) begin
            nib_o = nib_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_display.sv
// rtl/bin_to_bcd_display.sv - iterative binary-to-BCD converter for the display path (SIGNED_EN selects two's complement input)
module bin_to_bcd_display
    import bcd_pkg::*;
#(
    parameter int W      = 16,
    parameter int DIGITS = 5
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        start,
    input  logic [W-1:0]                Din,
    output logic                        busy,
    output logic                        done,
    output logic [BCD_NIB_W*DIGITS-1:0] bcd,
    output logic [2:0]                  nz,
    output logic                        neg
);

    localparam int             SW       = BCD_NIB_W * DIGITS;
    localparam int             CW       = $clog2(W + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(W - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [SW-1:0]   scratch_q, scratch_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   bcd_q, bcd_d;
    logic [2:0]      nz_q, nz_d;

    logic [SW-1:0]   scratch_adj;
    logic [2:0]      nz_calc;
    logic [W-1:0]    din_mag;

    // Per-digit add-3 correction applied to the scratch before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_i (scratch_q[g*BCD_NIB_W +: BCD_NIB_W]),
            .nib_o (scratch_adj[g*BCD_NIB_W +: BCD_NIB_W])
        );
    end

    // Index of the most significant nonzero digit of the finished scratch.
    always_comb begin
        nz_calc = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[i*BCD_NIB_W +: BCD_NIB_W] != '0) begin
                nz_calc = 3'(i);
            end
        end
    end

`ifdef SIGNED_EN
    logic neg_pend_q, neg_pend_d;
    logic neg_q, neg_d;

    assign din_mag = Din[W-1] ? (~Din + {{(W-1){1'b0}}, 1'b1}) : Din;
    assign neg     = neg_q;

    // Sign is captured with the operand and only made visible together with the digits.
    always_comb begin
        neg_pend_d = neg_pend_q;
        neg_d      = neg_q;
        if (state_q == ST_IDLE && start) begin
            neg_pend_d = Din[W-1];
        end
        if (state_q == ST_FIN) begin
            neg_d = neg_pend_q;
        end
    end

    // Sign registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            neg_pend_q <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            neg_pend_q <= neg_pend_d;
            neg_q      <= neg_d;
        end
    end
`else
    assign din_mag = Din;
    assign neg     = 1'b0;
`endif

    // Sequencer: load on start, W correct-and-shift steps, then publish the result.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        bcd_d     = bcd_q;
        nz_d      = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d   = din_mag;
                    scratch_d = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                bcd_d   = scratch_q;
                nz_d    = nz_calc;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            nz_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bcd_q     <= bcd_d;
            nz_q      <= nz_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign nz   = nz_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// tb/tb_bin_to_bcd_display.sv - directed self-checking bench for bin_to_bcd_display
module tb_bin_to_bcd_display;

    logic        CLK;
    logic        RST_N;
    logic        start;
    logic [15:0] Din;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic [2:0]  nz;
    logic        neg;

    int n_checks = 0;
    int n_pass   = 0;

    bin_to_bcd_display #(.W(16), .DIGITS(5)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .start (start),
        .Din   (Din),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .nz    (nz),
        .neg   (neg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one start pulse and return the number of cycles until done (-1 on timeout).
    task automatic convert(input logic [15:0] d, output int lat);
        Din   = d;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    int lat;
    int cyc;
    int n_done;
    int t1, t2;
    int viol;
    logic [19:0] r1, r2;

    initial begin
        RST_N = 1'b0;
        start = 1'b0;
        Din   = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_bcd",  {12'b0, bcd},  32'd0);
        check("rst_nz",   {29'b0, nz},   32'd0);
        check("rst_neg",  {31'b0, neg},  32'd0);
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // 1: zero, latency and pulse shape
        convert(16'd0, lat);
        check("zero_lat",       lat,             32'd17);
        check("zero_busy_done", {31'b0, busy},   32'd0);
        check("zero_bcd",       {12'b0, bcd},    32'h00000);
        check("zero_nz",        {29'b0, nz},     32'd0);
        @(posedge CLK); #1;
        check("done_one_cycle", {31'b0, done},   32'd0);

        // 2: ordinary values
        convert(16'd1234, lat);
        check("v1234_lat", lat,          32'd17);
        check("v1234_bcd", {12'b0, bcd}, 32'h01234);
        check("v1234_nz",  {29'b0, nz},  32'd3);
        check("v1234_neg", {31'b0, neg}, 32'd0);
        repeat (3) @(posedge CLK); #1;
        check("v1234_hold", {12'b0, bcd}, 32'h01234);

        convert(16'd10, lat);
        check("v10_bcd", {12'b0, bcd}, 32'h00010);
        check("v10_nz",  {29'b0, nz},  32'd1);

        convert(16'd10000, lat);
        check("v10000_bcd", {12'b0, bcd}, 32'h10000);
        check("v10000_nz",  {29'b0, nz},  32'd4);

`ifndef SIGNED_EN
        convert(16'd65535, lat);
        check("vmax_bcd", {12'b0, bcd}, 32'h65535);
        check("vmax_nz",  {29'b0, nz},  32'd4);
        check("vmax_neg", {31'b0, neg}, 32'd0);

        convert(16'hFFFB, lat);
        check("vfffb_bcd", {12'b0, bcd}, 32'h65531);
        check("vfffb_neg", {31'b0, neg}, 32'd0);
`endif

        // 3: start held high -> back-to-back conversions every 18 cycles
        @(posedge CLK); #1;
        Din   = 16'd7;
        start = 1'b1;
        @(posedge CLK); #1;
        Din = 16'd9;
        n_done = 0; viol = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        for (int i = 1; i <= 60 && n_done < 2; i++) begin
            @(posedge CLK); #1;
            if (done && busy) viol++;
            if (done) begin
                n_done++;
                if (n_done == 1) begin t1 = i; r1 = bcd; end
                else             begin t2 = i; r2 = bcd; start = 1'b0; end
            end
        end
        start = 1'b0;
        check("hold_first_lat", t1,           32'd17);
        check("hold_period",    t2 - t1,      32'd18);
        check("hold_bcd1",      {12'b0, r1},  32'h00007);
        check("hold_bcd2",      {12'b0, r2},  32'h00009);
        check("hold_no_overlap", viol,        32'd0);
        repeat (3) @(posedge CLK); #1;

        // 4: extra start and Din change mid-conversion are ignored
        Din   = 16'd100;
        start = 1'b1;
        @(posedge CLK); #1;
        start  = 1'b0;
        n_done = 0; t1 = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge CLK); #1;
            if (i == 4) begin Din = 16'd555; start = 1'b1; end
            if (i == 5) start = 1'b0;
            if (done) begin
                n_done++;
                if (n_done == 1) begin t1 = i; r1 = bcd; end
            end
        end
        check("ign_lat",   t1,          32'd17);
        check("ign_bcd",   {12'b0, r1}, 32'h00100);
        check("ign_count", n_done,      32'd1);
        check("ign_idle",  {31'b0, busy}, 32'd0);

        // 5: reset mid-conversion
        Din   = 16'd4321;
        start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_bcd",  {12'b0, bcd},  32'd0);
        check("abort_nz",   {29'b0, nz},   32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge CLK); #1;
            if (done || busy) n_done++;
        end
        check("abort_quiet", n_done, 32'd0);
        convert(16'd9876, lat);
        check("post_lat", lat,          32'd17);
        check("post_bcd", {12'b0, bcd}, 32'h09876);
        check("post_nz",  {29'b0, nz},  32'd3);

`ifdef SIGNED_EN
        // 6: signed operands
        convert(16'hFFFB, lat);
        check("sgn_m5_bcd", {12'b0, bcd}, 32'h00005);
        check("sgn_m5_neg", {31'b0, neg}, 32'd1);
        check("sgn_m5_nz",  {29'b0, nz},  32'd0);
        convert(16'h8000, lat);
        check("sgn_min_bcd", {12'b0, bcd}, 32'h32768);
        check("sgn_min_neg", {31'b0, neg}, 32'd1);
        check("sgn_min_nz",  {29'b0, nz},  32'd4);
        convert(16'd7, lat);
        check("sgn_p7_bcd", {12'b0, bcd}, 32'h00007);
        check("sgn_p7_neg", {31'b0, neg}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
